// File: rtl/wb_stage.sv
// Writeback stage: formats load data, arbitrates LSU and ALU results onto the
// regfile write port (registered) and bypass port (combinational).
module wb_stage #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_alu_valid,
  output logic               o_alu_ready,
  input  logic               i_alu_rdwen,
  input  logic [RFIDX_W-1:0] i_alu_rdidx,
  input  logic [XLEN-1:0]    i_alu_wdata,
  input  logic               i_lsu_valid,
  input  logic [RFIDX_W-1:0] i_lsu_rdidx,
  input  logic [2:0]         i_lsu_funct3,
  input  logic [1:0]         i_lsu_addr_lo,
  input  logic [XLEN-1:0]    i_lsu_rdata,
  output logic               o_rdwen,
  output logic [RFIDX_W-1:0] o_rdidx,
  output logic [XLEN-1:0]    o_rd_wdata,
  output logic               o_bypass_rdwen,
  output logic [RFIDX_W-1:0] o_bypass_rdidx,
  output logic [XLEN-1:0]    o_bypass_rd_wdata
);

  logic               skid_full_q, skid_full_d;
  logic               skid_rdwen_q, skid_rdwen_d;
  logic [RFIDX_W-1:0] skid_rdidx_q, skid_rdidx_d;
  logic [XLEN-1:0]    skid_wdata_q, skid_wdata_d;

  logic               rdwen_q, rdwen_d;
  logic [RFIDX_W-1:0] rdidx_q, rdidx_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;

  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [XLEN-1:0]    lsu_wdata;

  logic               alu_fire;
  logic               win_valid;
  logic               win_rdwen;
  logic [RFIDX_W-1:0] win_rdidx;
  logic [XLEN-1:0]    win_wdata;
  logic               bypass_en;

  // Halfword select ignores addr_lo[0]: the LSU only delivers aligned halves.
  assign ld_byte = i_lsu_rdata[{i_lsu_addr_lo, 3'b000} +: 8];
  assign ld_half = i_lsu_rdata[{i_lsu_addr_lo[1], 4'b0000} +: 16];

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    lsu_wdata = '0;
    case (i_lsu_funct3)
      3'b000:  lsu_wdata = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  lsu_wdata = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  lsu_wdata = i_lsu_rdata;
      3'b100:  lsu_wdata = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  lsu_wdata = {{(XLEN-16){1'b0}}, ld_half};
      default: lsu_wdata = '0;
    endcase
  end

  assign o_alu_ready = ~skid_full_q;
  assign alu_fire    = i_alu_valid & o_alu_ready;

  // LSU always wins; a pending skid entry outranks a fresh ALU result.
  always_comb begin
    win_valid = i_lsu_valid | skid_full_q | alu_fire;
    win_rdwen = 1'b1;
    win_rdidx = i_lsu_rdidx;
    win_wdata = lsu_wdata;
    if (!i_lsu_valid) begin
      if (skid_full_q) begin
        win_rdwen = skid_rdwen_q;
        win_rdidx = skid_rdidx_q;
        win_wdata = skid_wdata_q;
      end else begin
        win_rdwen = i_alu_rdwen;
        win_rdidx = i_alu_rdidx;
        win_wdata = i_alu_wdata;
      end
    end
  end

  assign bypass_en         = win_valid & win_rdwen & (|win_rdidx);
  assign o_bypass_rdwen    = bypass_en;
  assign o_bypass_rdidx    = win_rdidx;
  assign o_bypass_rd_wdata = win_wdata;

  always_comb begin
    skid_full_d  = skid_full_q;
    skid_rdwen_d = skid_rdwen_q;
    skid_rdidx_d = skid_rdidx_q;
    skid_wdata_d = skid_wdata_q;
    if (skid_full_q) begin
      if (!i_lsu_valid) skid_full_d = 1'b0;
    end else if (alu_fire && i_lsu_valid) begin
      skid_full_d  = 1'b1;
      skid_rdwen_d = i_alu_rdwen;
      skid_rdidx_d = i_alu_rdidx;
      skid_wdata_d = i_alu_wdata;
    end

    rdwen_d = bypass_en;
    rdidx_d = bypass_en ? win_rdidx : rdidx_q;
    wdata_d = bypass_en ? win_wdata : wdata_q;
  end

  // NOTE: the skid payload is reset too; it is only a few flops, and it keeps
  // a stale entry from ever being observable after reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      skid_full_q  <= 1'b0;
      skid_rdwen_q <= 1'b0;
      skid_rdidx_q <= '0;
      skid_wdata_q <= '0;
      rdwen_q      <= 1'b0;
      rdidx_q      <= '0;
      wdata_q      <= '0;
    end else begin
      skid_full_q  <= skid_full_d;
      skid_rdwen_q <= skid_rdwen_d;
      skid_rdidx_q <= skid_rdidx_d;
      skid_wdata_q <= skid_wdata_d;
      rdwen_q      <= rdwen_d;
      rdidx_q      <= rdidx_d;
      wdata_q      <= wdata_d;
    end
  end

  assign o_rdwen    = rdwen_q;
  assign o_rdidx    = rdidx_q;
  assign o_rd_wdata = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected bypass/write events
// tagged with their cycle; a negedge monitor pops and compares them.
module tb_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_alu_valid, o_alu_ready, i_alu_rdwen;
  logic [4:0]  i_alu_rdidx;
  logic [31:0] i_alu_wdata;
  logic        i_lsu_valid;
  logic [4:0]  i_lsu_rdidx;
  logic [2:0]  i_lsu_funct3;
  logic [1:0]  i_lsu_addr_lo;
  logic [31:0] i_lsu_rdata;
  logic        o_rdwen, o_bypass_rdwen;
  logic [4:0]  o_rdidx, o_bypass_rdidx;
  logic [31:0] o_rd_wdata, o_bypass_rd_wdata;

  wb_stage #(.XLEN(32), .RFIDX_W(5)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_rdwen(i_alu_rdwen), .i_alu_rdidx(i_alu_rdidx), .i_alu_wdata(i_alu_wdata),
    .i_lsu_valid(i_lsu_valid), .i_lsu_rdidx(i_lsu_rdidx), .i_lsu_funct3(i_lsu_funct3),
    .i_lsu_addr_lo(i_lsu_addr_lo), .i_lsu_rdata(i_lsu_rdata),
    .o_rdwen(o_rdwen), .o_rdidx(o_rdidx), .o_rd_wdata(o_rd_wdata),
    .o_bypass_rdwen(o_bypass_rdwen), .o_bypass_rdidx(o_bypass_rdidx),
    .o_bypass_rd_wdata(o_bypass_rd_wdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          cyc;
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t bp_q[$];
  exp_t wr_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bypass shows the winner in cycle c; the write port shows it in c+1.
  task automatic expect_wb(input int c, input logic [4:0] idx, input logic [31:0] data);
    bp_q.push_back('{c, idx, data});
    wr_q.push_back('{c + 1, idx, data});
  endtask

  always @(negedge i_clk) begin
    if (mon_en && o_bypass_rdwen) begin
      if (bp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL bp_unexpected: got idx %0d data 0x%08h, none expected (cycle %0d)",
                 o_bypass_rdidx, o_bypass_rd_wdata, cyc);
      end else begin
        exp_t e;
        e = bp_q.pop_front();
        check("bp_cycle", cyc, e.cyc);
        check("bp_idx", {27'd0, o_bypass_rdidx}, {27'd0, e.idx});
        check("bp_data", o_bypass_rd_wdata, e.data);
      end
    end
    if (mon_en && o_rdwen) begin
      if (wr_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wr_unexpected: got idx %0d data 0x%08h, none expected (cycle %0d)",
                 o_rdidx, o_rd_wdata, cyc);
      end else begin
        exp_t e;
        e = wr_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_idx", {27'd0, o_rdidx}, {27'd0, e.idx});
        check("wr_data", o_rd_wdata, e.data);
      end
    end
  end

  task automatic idle_inputs();
    i_alu_valid = 1'b0; i_alu_rdwen = 1'b0; i_alu_rdidx = '0; i_alu_wdata = '0;
    i_lsu_valid = 1'b0; i_lsu_rdidx = '0; i_lsu_funct3 = '0; i_lsu_addr_lo = '0;
    i_lsu_rdata = '0;
  endtask

  // Advance to the next cycle and clear all inputs; returns that cycle's number.
  task automatic next_cycle(output int c);
    @(posedge i_clk);
    #1;
    idle_inputs();
    c = cyc;
  endtask

  task automatic drive_alu(input logic rdwen, input logic [4:0] idx, input logic [31:0] data);
    i_alu_valid = 1'b1; i_alu_rdwen = rdwen; i_alu_rdidx = idx; i_alu_wdata = data;
  endtask

  task automatic drive_lsu(input logic [4:0] idx, input logic [2:0] f3,
                           input logic [1:0] alo, input logic [31:0] rdata);
    i_lsu_valid = 1'b1; i_lsu_rdidx = idx; i_lsu_funct3 = f3;
    i_lsu_addr_lo = alo; i_lsu_rdata = rdata;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_vecs[8];

  initial begin
    int c;
    ld_vecs[0] = '{3'b000, 2'd3, 32'hFFFF_FF80};  // LB byte3, negative
    ld_vecs[1] = '{3'b100, 2'd3, 32'h0000_0080};  // LBU byte3
    ld_vecs[2] = '{3'b001, 2'd2, 32'hFFFF_80FF};  // LH upper half
    ld_vecs[3] = '{3'b101, 2'd0, 32'h0000_7F01};  // LHU lower half
    ld_vecs[4] = '{3'b010, 2'd0, 32'h80FF_7F01};  // LW
    ld_vecs[5] = '{3'b000, 2'd1, 32'h0000_007F};  // LB byte1, positive
    ld_vecs[6] = '{3'b001, 2'd3, 32'hFFFF_80FF};  // LH, addr_lo[0] ignored
    ld_vecs[7] = '{3'b011, 2'd0, 32'h0000_0000};  // undefined funct3

    idle_inputs();
    i_rstn = 1'b0;
    #3;
    check("rst_rdwen", {31'd0, o_rdwen}, 32'd0);
    check("rst_rdidx", {27'd0, o_rdidx}, 32'd0);
    check("rst_wdata", o_rd_wdata, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    mon_en = 1'b1;
    #1;
    check("rst_alu_ready", {31'd0, o_alu_ready}, 32'd1);

    // ALU only
    next_cycle(c);
    drive_alu(1'b1, 5'd5, 32'h0000_1234);
    check("alu_ready_single", {31'd0, o_alu_ready}, 32'd1);
    expect_wb(c, 5'd5, 32'h0000_1234);
    next_cycle(c);

    // Load formatting, back to back
    foreach (ld_vecs[i]) begin
      next_cycle(c);
      drive_lsu(5'(10 + i), ld_vecs[i].f3, ld_vecs[i].alo, 32'h80FF_7F01);
      expect_wb(c, 5'(10 + i), ld_vecs[i].exp);
    end
    next_cycle(c);

    // Collision: LSU rd7 and ALU rd8 in the same cycle
    next_cycle(c);
    drive_lsu(5'd7, 3'b010, 2'd0, 32'h0000_0077);
    drive_alu(1'b1, 5'd8, 32'h0000_0088);
    check("coll_ready_c0", {31'd0, o_alu_ready}, 32'd1);
    expect_wb(c, 5'd7, 32'h0000_0077);
    next_cycle(c);
    check("coll_ready_c1", {31'd0, o_alu_ready}, 32'd0);
    expect_wb(c, 5'd8, 32'h0000_0088);
    next_cycle(c);
    check("coll_ready_c2", {31'd0, o_alu_ready}, 32'd1);

    // Starvation: three loads with the ALU held valid
    for (int k = 0; k < 3; k++) begin
      next_cycle(c);
      drive_lsu(5'(21 + k), 3'b010, 2'd0, 32'h1000_0000 + k);
      drive_alu(1'b1, 5'd20, 32'h0000_000A);
      check("starve_ready", {31'd0, o_alu_ready}, (k == 0) ? 32'd1 : 32'd0);
      expect_wb(c, 5'(21 + k), 32'h1000_0000 + k);
    end
    next_cycle(c);
    drive_alu(1'b1, 5'd20, 32'h0000_000A);
    check("starve_ready_c3", {31'd0, o_alu_ready}, 32'd0);
    expect_wb(c, 5'd20, 32'h0000_000A);
    next_cycle(c);
    check("starve_ready_c4", {31'd0, o_alu_ready}, 32'd1);

    // x0 and rdwen=0 results are consumed without writing
    next_cycle(c);
    drive_alu(1'b1, 5'd0, 32'h0000_DEAD);
    check("x0_ready", {31'd0, o_alu_ready}, 32'd1);
    next_cycle(c);
    drive_alu(1'b0, 5'd3, 32'h0000_BEEF);
    check("x0_rdwen", {31'd0, o_rdwen}, 32'd0);
    check("x0_handshake_ready", {31'd0, o_alu_ready}, 32'd1);
    next_cycle(c);
    check("nowen_rdwen", {31'd0, o_rdwen}, 32'd0);
    check("nowen_ready", {31'd0, o_alu_ready}, 32'd1);

    // Reset while the skid is full: the pending write and skid entry vanish
    next_cycle(c);
    drive_lsu(5'd25, 3'b010, 2'd0, 32'h0000_0025);
    drive_alu(1'b1, 5'd26, 32'h0000_0026);
    bp_q.push_back('{c, 5'd25, 32'h0000_0025});
    next_cycle(c);
    check("skid_full_ready", {31'd0, o_alu_ready}, 32'd0);
    #1;
    i_rstn = 1'b0;
    #1;
    check("mid_rst_rdwen", {31'd0, o_rdwen}, 32'd0);
    check("mid_rst_rdidx", {27'd0, o_rdidx}, 32'd0);
    check("mid_rst_wdata", o_rd_wdata, 32'd0);
    check("mid_rst_bypass", {31'd0, o_bypass_rdwen}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, o_alu_ready}, 32'd1);
    repeat (4) next_cycle(c);
    check("post_rst_rdwen", {31'd0, o_rdwen}, 32'd0);

    @(negedge i_clk);
    check("bp_queue_drained", bp_q.size(), 32'd0);
    check("wr_queue_drained", wr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage; sits directly upstream of the general register file.
- Merges single-cycle ALU results and load responses from the LSU, and formats load data (byte/half extraction, sign/zero extension).
- Arbitrates these sources onto the regfile's single write port (registered) and its bypass port (same-cycle).
- Holds a displaced ALU result in a one-entry skid buffer, applying backpressure to the ALU only when that buffer is full.

Parameters:
- XLEN, 32, data width.
- RFIDX_W, 5, register index width.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_alu_valid  input  1  ALU result valid.
- o_alu_ready  output  1  stage can accept an ALU result this cycle.
- i_alu_rdwen  input  1  ALU result writes rd.
- i_alu_rdidx  input  RFIDX_W  ALU destination index.
- i_alu_wdata  input  XLEN  ALU result.
- i_lsu_valid  input  1  load response valid; always accepted, no ready.
- i_lsu_rdidx  input  RFIDX_W  load destination index.
- i_lsu_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_lsu_addr_lo  input  2  load address bits [1:0].
- i_lsu_rdata  input  XLEN  raw aligned word from memory.
- o_rdwen  output  1  regfile write enable (registered).
- o_rdidx  output  RFIDX_W  regfile write index (registered).
- o_rd_wdata  output  XLEN  regfile write data (registered).
- o_bypass_rdwen  output  1  same-cycle bypass enable.
- o_bypass_rdidx  output  RFIDX_W  same-cycle bypass index.
- o_bypass_rd_wdata  output  XLEN  same-cycle bypass data.

Behaviour:
- Reset (i_rstn low, asynchronous):
  - o_rdwen=0, o_rdidx=0, o_rd_wdata=0.
  - Skid buffer cleared to empty.
  - o_alu_ready=1 once reset is released.
- Load formatting (combinational):
  - LB/LBU select byte i_lsu_addr_lo.
  - LH/LHU select half i_lsu_addr_lo[1]; i_lsu_addr_lo[0] is ignored, since the LSU guarantees alignment.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes the word unchanged.
  - Undefined funct3 encodings yield 0 with write enabled.
- Candidates per cycle:
  - L = i_lsu_valid.
  - A = skid entry if skid is full; otherwise (i_alu_valid & o_alu_ready).
- Arbitration:
  - If L: the LSU wins.
  - Else if A: the ALU candidate wins.
  - Else: no winner.
- o_alu_ready = ~skid_full.
- Skid buffer:
  - New ALU accepted (i_alu_valid & o_alu_ready) in the same cycle as L → the ALU result is captured into the skid buffer (skid_full=1 next cycle).
  - Skid full and no L → the skid entry is written back and skid_full=0 next cycle; o_alu_ready is still 0 in that cycle, so a new ALU result is accepted one cycle later.
  - Skid full and L → the skid holds.
  - Back-to-back loads starve the ALU indefinitely; the issue stage bounds load bursts.
- Winner presentation:
  - Bypass outputs show the winner combinationally in the cycle of arbitration.
  - At the next rising edge, the winner is registered onto o_rdwen/o_rdidx/o_rd_wdata.
  - Load-to-write-port latency = 1 cycle; bypass latency = 0.
- x0 suppression:
  - Any winner with index 0, or an ALU winner with i_alu_rdwen=0 / skid rdwen=0, drives o_bypass_rdwen=0 and o_rdwen=0 next cycle.
  - The ALU result is still consumed (handshake completes).
- No winner → o_bypass_rdwen=0, and o_rdwen=0 next cycle. o_rdidx/o_rd_wdata hold their previous values.
- Ordering: the issue stage never has a load and an ALU op outstanding to the same rd, so no same-rd reordering checks are done here.
- Reset mid-operation: the skid contents and the pending write are discarded; no write occurs after the reset edge.

Test Plan:
- ALU only: valid, rdidx=5, data=0x1234 → same cycle bypass en=1 idx=5 data=0x1234; next cycle o_rdwen=1 idx=5 data=0x1234.
- Loads, i_lsu_rdata=0x80FF7F01:
  - LB addr_lo=3 → 0xFFFFFF80.
  - LBU addr_lo=3 → 0x00000080.
  - LH addr_lo=2 → 0xFFFF80FF.
  - LHU addr_lo=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Collision: same cycle LSU rd=7 and ALU rd=8 → cycle0 bypass rd7; cycle1 o_rdwen rd7, o_alu_ready=0, bypass rd8; cycle2 o_rdwen rd8, o_alu_ready=1.
- Starvation/backpressure: 3 consecutive LSU valids with ALU valid held → ALU accepted cycle0 into skid, o_alu_ready=0 cycles1-3; skid written back cycle3 (bypass), o_rdwen cycle4.
- x0 writes: ALU rdidx=0 data=0xDEAD → o_bypass_rdwen=0, o_rdwen stays 0; the handshake still completes.
- Reset asserted while skid full → outputs zero immediately (asynchronously); after release, o_alu_ready=1 and no stale write appears.
